// File: rtl/i2s_mic_array_rx.sv
// I2S master receiver for the three-microphone array: drives WS and deserialises
// the shared-WS SD lines into one parallel word per half-frame (valid/ready out).
module i2s_mic_array_rx #(
    parameter int NUM_MICS  = 3,
    parameter int DATA_BITS = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [NUM_MICS-1:0]           sd,
    output logic                          ws,
    output logic [NUM_MICS*DATA_BITS-1:0] out_data,
    output logic                          out_chan,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [4:0] LAST_K = 5'(DATA_BITS);

    state_t                               state;
    logic [5:0]                           bcnt;
    logic [5:0]                           bcnt_nxt;
    logic [4:0]                           k;
    logic                                 active;
    logic                                 capture;
    logic                                 last_bit;
    logic                                 load_pend;
    logic                                 pend_chan;
    logic [NUM_MICS-1:0][DATA_BITS-1:0]   shreg;

    assign k        = bcnt[4:0];
    assign active   = (state != IDLE);
    assign capture  = active && (k != 5'd0) && (k <= LAST_K);
    assign last_bit = active && (k == LAST_K);

    always_comb begin
        bcnt_nxt = bcnt + 6'd1;
        if (state == IDLE)
            bcnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            bcnt  <= '0;
            ws    <= 1'b0;
        end else begin
            bcnt <= bcnt_nxt;
            ws   <= bcnt_nxt[5];
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (en) begin
                        state <= RUN;
                    end else if (bcnt == 6'd63) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The load is deferred one edge after the LSB via load_pend, so DATA_BITS=31
    // (load at k=0 of the next slot) also works when that edge falls in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            load_pend <= 1'b0;
            pend_chan <= 1'b0;
            out_data  <= '0;
            out_chan  <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (capture) begin
                for (int unsigned i = 0; i < unsigned'(NUM_MICS); i++)
                    shreg[i] <= DATA_BITS'({shreg[i], sd[i]});
            end
            load_pend <= last_bit;
            if (last_bit)
                pend_chan <= bcnt[5];
            if (load_pend) begin
                out_data  <= shreg;
                out_chan  <= pend_chan;
                out_valid <= 1'b1;
                if (out_valid && !out_ready)
                    overrun <= 1'b1;
                else if (clr_overrun)
                    overrun <= 1'b0;
            end else begin
                if (out_ready)
                    out_valid <= 1'b0;
                if (clr_overrun)
                    overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_mic_array_rx.sv
// Bench for i2s_mic_array_rx: frame/slot-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_i2s_mic_array_rx;

    localparam int DB = 24;
    localparam int NM = 3;

    localparam logic [71:0] WORD_L = {24'h7FFFFF, 24'h123456, 24'h800001};
    localparam logic [71:0] WORD_R = {24'hA5A5A5, 24'hFFFFFF, 24'h000000};
    localparam logic [47:0] WORD16 = {16'h0000, 16'hFFFF, 16'h0000};
    localparam logic [92:0] WORD31 = {31'h7FFFFFFF, 31'h0, 31'h7FFFFFFF};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic out_ready = 1'b1;
    logic clr_overrun = 1'b0;
    logic [NM-1:0] sd = '0;

    logic ws, out_chan, out_valid, overrun, busy;
    logic [NM*DB-1:0] out_data;

    logic ws16, chan16, valid16, ovr16, busy16;
    logic [47:0] data16;
    logic ws31, chan31, valid31, ovr31, busy31;
    logic [92:0] data31;

    int n_cmp = 0;
    int n_bad = 0;
    logic pat_mode = 1'b1;
    logic [23:0] pat [2][3];

    // reference model state
    logic        m_active, m_prev_en, m_pend, m_pend_chan;
    int          m_cnt;
    logic [23:0] m_acc [3];
    logic [71:0] m_pend_word, m_data;
    logic        m_chan, m_valid, m_ovr;

    always #5 clk = ~clk;

    i2s_mic_array_rx #(.NUM_MICS(NM), .DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset), .en(en), .sd(sd), .ws(ws),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun), .clr_overrun(clr_overrun),
        .busy(busy)
    );

    i2s_mic_array_rx #(.NUM_MICS(3), .DATA_BITS(16)) dut16 (
        .clk(clk), .reset(reset), .en(en), .sd(3'b010), .ws(ws16),
        .out_data(data16), .out_chan(chan16), .out_valid(valid16),
        .out_ready(1'b1), .overrun(ovr16), .clr_overrun(1'b0),
        .busy(busy16)
    );

    i2s_mic_array_rx #(.NUM_MICS(3), .DATA_BITS(31)) dut31 (
        .clk(clk), .reset(reset), .en(en), .sd(3'b101), .ws(ws31),
        .out_data(data31), .out_chan(chan31), .out_valid(valid31),
        .out_ready(1'b1), .overrun(ovr31), .clr_overrun(1'b0),
        .busy(busy31)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endtask

    // Model: 64-cycle frames; a frame stops at its end only if en was low in its last two cycles.
    always @(posedge clk or posedge reset) begin : model
        int k;
        if (reset) begin
            m_active = 0; m_prev_en = 0; m_pend = 0; m_pend_chan = 0; m_cnt = 0;
            for (int i = 0; i < 3; i++) m_acc[i] = '0;
            m_pend_word = '0; m_data = '0; m_chan = 0; m_valid = 0; m_ovr = 0;
        end else begin
            if (m_pend) begin
                if (m_valid && !out_ready) m_ovr = 1;
                else if (clr_overrun) m_ovr = 0;
                m_data  = m_pend_word;
                m_chan  = m_pend_chan;
                m_valid = 1;
            end else begin
                if (m_valid && out_ready) m_valid = 0;
                if (clr_overrun) m_ovr = 0;
            end
            m_pend = 0;
            if (m_active) begin
                k = m_cnt % 32;
                if (k >= 1 && k <= DB)
                    for (int i = 0; i < 3; i++) m_acc[i] = {m_acc[i][DB-2:0], sd[i]};
                if (k == DB) begin
                    m_pend = 1;
                    m_pend_chan = (m_cnt >= 32);
                    for (int i = 0; i < 3; i++) m_pend_word[i*DB +: DB] = m_acc[i];
                end
                if (m_cnt == 63 && !m_prev_en && !en) begin
                    m_active = 0;
                    m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % 64;
                end
            end else if (en) begin
                m_active = 1;
                m_cnt = 0;
            end
            m_prev_en = en;
        end
    end

    // Microphones: MSB in cycle 1 of each slot, driven away from the sampling edge.
    always @(negedge clk) begin : mic_drive
        int kk, ch;
        kk = m_cnt % 32;
        ch = m_cnt / 32;
        for (int i = 0; i < 3; i++) begin
            if (!pat_mode)                            sd[i] = 1'($urandom);
            else if (m_active && kk >= 1 && kk <= DB) sd[i] = pat[ch][i][DB-kk];
            else                                      sd[i] = 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        #1;
        chk("ws",        128'(ws),        128'(m_cnt >= 32));
        chk("busy",      128'(busy),      128'(m_active));
        chk("out_valid", 128'(out_valid), 128'(m_valid));
        chk("out_chan",  128'(out_chan),  128'(m_chan));
        chk("out_data",  128'(out_data),  128'(m_data));
        chk("overrun",   128'(overrun),   128'(m_ovr));
    end

    task automatic wait_k(input int kk, input string name);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (m_active && (m_cnt % 32) == kk) return;
        end
        timeout(name);
    endtask

    task automatic wait_cnt(input int c, input string name);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (m_active && m_cnt == c) return;
        end
        timeout(name);
    endtask

    initial begin
        pat[0][0] = 24'h800001; pat[0][1] = 24'h123456; pat[0][2] = 24'h7FFFFF;
        pat[1][0] = 24'h000000; pat[1][1] = 24'hFFFFFF; pat[1][2] = 24'hA5A5A5;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ws", 128'(ws), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_data", 128'(out_data), 128'(0));
        chk("rst_overrun", 128'(overrun), 128'(0));
        @(negedge clk); reset = 1'b0;
        @(negedge clk); en = 1'b1; out_ready = 1'b1;

        // First frame timing pinned by literals
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            #1;
            if (j == 18) chk("d16_valid_early", 128'(valid16), 128'(0));
            if (j == 19) begin
                chk("d16_valid", 128'(valid16), 128'(1));
                chk("d16_data", 128'(data16), 128'(WORD16));
            end
            if (j == 26) chk("valid_early", 128'(out_valid), 128'(0));
            if (j == 27) begin
                chk("L_valid", 128'(out_valid), 128'(1));
                chk("L_chan", 128'(out_chan), 128'(0));
                chk("L_data", 128'(out_data), 128'(WORD_L));
            end
            if (j == 32) chk("ws_low31", 128'(ws), 128'(0));
            if (j == 33) chk("ws_high32", 128'(ws), 128'(1));
            if (j == 34) begin
                chk("d31_valid", 128'(valid31), 128'(1));
                chk("d31_chan", 128'(chan31), 128'(0));
                chk("d31_data", 128'(data31), 128'(WORD31));
            end
            if (j == 59) begin
                chk("R_chan", 128'(out_chan), 128'(1));
                chk("R_data", 128'(out_data), 128'(WORD_R));
                chk("R_overrun", 128'(overrun), 128'(0));
            end
        end

        // Back-pressure and overrun handling
        out_ready = 1'b0;
        repeat (96) @(negedge clk);
        #1;
        chk("ovr_set", 128'(overrun), 128'(1));
        chk("ovr_valid", 128'(out_valid), 128'(1));
        wait_k(10, "wait_clr1"); clr_overrun = 1'b1;
        @(negedge clk); clr_overrun = 1'b0; #1;
        chk("ovr_cleared", 128'(overrun), 128'(0));
        wait_k(25, "wait_clr_load"); clr_overrun = 1'b1;
        @(negedge clk); clr_overrun = 1'b0; #1;
        chk("ovr_set_wins", 128'(overrun), 128'(1));
        wait_k(10, "wait_clr2"); clr_overrun = 1'b1;
        @(negedge clk); clr_overrun = 1'b0;
        wait_k(25, "wait_ready_load"); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0; #1;
        chk("rdy_load_valid", 128'(out_valid), 128'(1));
        chk("rdy_load_ovr", 128'(overrun), 128'(0));
        out_ready = 1'b1;

        // Stop mid-frame: right word still produced, then idle
        wait_cnt(40, "wait_stop40"); en = 1'b0;
        wait_cnt(58, "wait_stop58"); #1;
        chk("drain_R_valid", 128'(out_valid), 128'(1));
        chk("drain_R_chan", 128'(out_chan), 128'(1));
        chk("drain_R_data", 128'(out_data), 128'(WORD_R));
        wait_cnt(63, "wait_stop63");
        @(negedge clk); #1;
        chk("stop_busy", 128'(busy), 128'(0));
        chk("stop_ws", 128'(ws), 128'(0));

        // Stop then resume within the same frame: no interruption
        en = 1'b1;
        wait_cnt(40, "wait_resume40"); en = 1'b0;
        wait_cnt(50, "wait_resume50"); en = 1'b1;
        wait_cnt(63, "wait_resume63");
        @(negedge clk); #1;
        chk("resume_busy", 128'(busy), 128'(1));

        // Reset mid-capture
        out_ready = 1'b0;
        wait_cnt(10, "wait_rst10"); reset = 1'b1; #1;
        chk("midrst_ws", 128'(ws), 128'(0));
        chk("midrst_valid", 128'(out_valid), 128'(0));
        @(negedge clk); reset = 1'b0;
        repeat (27) @(negedge clk);
        #1;
        chk("post_rst_valid", 128'(out_valid), 128'(1));
        chk("post_rst_data", 128'(out_data), 128'(WORD_L));
        out_ready = 1'b1;

        // Randomized traffic
        @(negedge clk); pat_mode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) en = ~en;
            out_ready   = ($urandom_range(0, 3) != 0);
            clr_overrun = ($urandom_range(0, 29) == 0);
            reset       = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk); reset = 1'b0; clr_overrun = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
